// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : CPU bus responder backed by a word-organised RAM window with
//            configurable read/write wait states and sized stores.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_WAIT  = 1,
    parameter int          WRITE_WAIT = 0,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic [1:0]  mem_width,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_ok
);

    localparam int          c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] c_WIN_MASK = ~((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1);
    localparam logic [3:0]  c_RD_WAIT  = 4'(READ_WAIT);
    localparam logic [3:0]  c_WR_WAIT  = 4'(WRITE_WAIT);

    if (READ_WAIT < 0 || READ_WAIT > 15) begin : g_bad_read_wait
        $error("mem_responder: READ_WAIT must be in 0..15");
    end
    if (WRITE_WAIT < 0 || WRITE_WAIT > 15) begin : g_bad_write_wait
        $error("mem_responder: WRITE_WAIT must be in 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic        is_wr_q, is_wr_d;

    logic [31:0] ram_q [c_DEPTH];

    logic                  w_req_live;
    logic                  w_hit;
    logic                  w_commit;
    logic                  w_drive;
    logic [3:0]            w_load_cnt;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [1:0]            w_lane;
    logic [31:0]           w_word;
    logic [31:0]           w_rdata;
    logic [31:0]           w_wword;
    logic [3:0]            w_be;

    assign w_req_live = is_wr_q ? mem_write : mem_read;
    assign w_hit      = (addr_q & c_WIN_MASK) == BASE_ADDR;
    assign w_widx     = addr_q[DEPTH_LOG2+1:2];
    assign w_lane     = addr_q[1:0];
    assign w_word     = ram_q[w_widx];
    assign w_load_cnt = mem_write ? c_WR_WAIT : c_RD_WAIT;
    assign w_drive    = (state_q == ST_ACK) && !is_wr_q;
    assign mem_data   = w_drive ? w_rdata : 32'bz;

    // Rotate so the addressed byte/halfword lands in the low bits.
    always_comb begin
        w_rdata = 32'h0;
        if (w_hit) begin
            case (w_lane)
                2'd0:    w_rdata = w_word;
                2'd1:    w_rdata = {w_word[7:0],  w_word[31:8]};
                2'd2:    w_rdata = {w_word[15:0], w_word[31:16]};
                default: w_rdata = {w_word[23:0], w_word[31:24]};
            endcase
        end
    end

    always_comb begin
        w_wword = wdata_q;
        w_be    = 4'b0000;
        case (width_q)
            2'd0: begin
                w_wword = {4{wdata_q[7:0]}};
                w_be    = 4'b0001 << w_lane;
            end
            2'd1: begin
                w_wword = {2{wdata_q[15:0]}};
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            2'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        width_d  = width_q;
        is_wr_d  = is_wr_q;
        mem_ok   = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    addr_d  = mem_addr;
                    width_d = mem_width;
                    wdata_d = mem_data;
                    is_wr_d = mem_write;
                    cnt_d   = w_load_cnt;
                    state_d = (w_load_cnt == 4'd0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!w_req_live) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (w_req_live) begin
                    mem_ok   = 1'b1;
                    w_commit = is_wr_q && w_hit;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            width_q <= 2'd0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            is_wr_q <= is_wr_d;
        end
    end

    // RAM contents deliberately survive reset; width 3 yields no byte enables.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    ram_q[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder over three wait-state configs.
// Revision : 1.0
// ============================================================================
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] WIN  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, drv = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [1:0]  width = 2'd0;
    int          sel = 0;

    always #5 clk = ~clk;

    wire [31:0] bus0, bus1, bus2;
    logic       ok0, ok1, ok2;
    wire        rd0 = rd && (sel == 0);
    wire        rd1 = rd && (sel == 1);
    wire        rd2 = rd && (sel == 2);
    wire        wr0 = wr && (sel == 0);
    wire        wr1 = wr && (sel == 1);
    wire        wr2 = wr && (sel == 2);

    assign bus0 = (drv && sel == 0) ? wdata : 32'bz;
    assign bus1 = (drv && sel == 1) ? wdata : 32'bz;
    assign bus2 = (drv && sel == 2) ? wdata : 32'bz;

    wire rel0 = (bus0 === 32'bz);
    wire rel1 = (bus1 === 32'bz);
    wire rel2 = (bus2 === 32'bz);

    mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .READ_WAIT(1), .WRITE_WAIT(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_data(bus0), .mem_width(width),
        .mem_read(rd0), .mem_write(wr0), .mem_ok(ok0));
    mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .READ_WAIT(3), .WRITE_WAIT(2), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_data(bus1), .mem_width(width),
        .mem_read(rd1), .mem_write(wr1), .mem_ok(ok1));
    mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .READ_WAIT(0), .WRITE_WAIT(0), .INIT_FILE("")) u_dut2 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_data(bus2), .mem_width(width),
        .mem_read(rd2), .mem_write(wr2), .mem_ok(ok2));

    logic        obs_ok, obs_rel;
    logic [31:0] obs_data;
    always_comb begin
        obs_ok   = ok2;
        obs_rel  = rel2;
        obs_data = bus2;
        if (sel == 0) begin
            obs_ok = ok0; obs_rel = rel0; obs_data = bus0;
        end else if (sel == 1) begin
            obs_ok = ok1; obs_rel = rel1; obs_data = bus1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // One request held until its ack; d is write data or expected read data.
    task automatic xfer(input int unit, input bit is_wr, input logic [31:0] a,
                        input logic [1:0] w, input logic [31:0] d, input int lat, input bit scr);
        exp_t e;
        bit   seen;
        int   k;
        @(posedge clk); #1;
        sel = unit; addr = a; width = w; wdata = d;
        drv = is_wr; rd = !is_wr; wr = is_wr;
        sb.push_back('{is_rd: !is_wr, data: d, lat: lat});
        seen = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (obs_ok) begin
                seen = 1'b1;
                break;
            end
            if (!is_wr) check("bus_released", {31'b0, obs_rel}, 32'd1);
            if (k == 0 && scr) begin
                @(posedge clk); #1;
                addr = ~a; width = ~w; wdata = ~d;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", k, e.lat);
            if (e.is_rd) check("rdata", obs_data, e.data);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; drv = 1'b0;
        @(negedge clk);
        check("ok_one_cycle", {31'b0, obs_ok}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            sel = u; #1;
            check("reset_ok", {31'b0, obs_ok}, 32'd0);
            check("reset_bus", {31'b0, obs_rel}, 32'd1);
        end
        rst = 1'b0;

        // Unit 0: READ_WAIT=1, WRITE_WAIT=0
        xfer(0, 1, BASE,      2'd2, 32'hE3A0_0001, 1, 0);
        xfer(0, 0, BASE,      2'd0, 32'hE3A0_0001, 2, 0);
        xfer(0, 1, BASE + 4,  2'd2, 32'h1122_3344, 1, 0);
        xfer(0, 1, BASE + 6,  2'd0, 32'hCDCD_CDAB, 1, 0);
        xfer(0, 0, BASE + 4,  2'd2, 32'h11AB_3344, 2, 0);
        xfer(0, 0, BASE + 6,  2'd1, 32'h3344_11AB, 2, 0);
        xfer(0, 1, BASE + 8,  2'd2, 32'h0000_0000, 1, 0);
        xfer(0, 1, BASE + 9,  2'd1, 32'h5555_BEEF, 1, 0);
        xfer(0, 0, BASE + 8,  2'd2, 32'h0000_BEEF, 2, 0);
        xfer(0, 1, BASE + 10, 2'd1, 32'h1234_CAFE, 1, 0);
        xfer(0, 0, BASE + 8,  2'd2, 32'hCAFE_BEEF, 2, 0);
        xfer(0, 1, BASE + 8,  2'd3, 32'hFFFF_FFFF, 1, 0);
        xfer(0, 0, BASE + 8,  2'd2, 32'hCAFE_BEEF, 2, 0);
        xfer(0, 0, BASE + WIN, 2'd2, 32'h0000_0000, 2, 0);
        xfer(0, 1, BASE + WIN, 2'd2, 32'h1234_5678, 1, 0);
        xfer(0, 0, BASE,      2'd2, 32'hE3A0_0001, 2, 0);
        xfer(0, 1, BASE + 12, 2'd2, 32'hA5A5_A5A5, 1, 1);
        xfer(0, 0, BASE + 12, 2'd2, 32'hA5A5_A5A5, 2, 1);

        // Unit 1: READ_WAIT=3, WRITE_WAIT=2
        xfer(1, 1, BASE + 16, 2'd2, 32'h0BAD_F00D, 3, 0);
        xfer(1, 0, BASE + 16, 2'd2, 32'h0BAD_F00D, 4, 0);

        // Read dropped in the second WAIT cycle
        @(posedge clk); #1;
        sel = 1; addr = BASE + 16; rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_early_ok", {31'b0, obs_ok}, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_ok", {31'b0, obs_ok}, 32'd0);
            check("abort_bus", {31'b0, obs_rel}, 32'd1);
        end
        xfer(1, 0, BASE + 16, 2'd2, 32'h0BAD_F00D, 4, 0);

        // Reset in the second WAIT cycle of a write
        @(posedge clk); #1;
        sel = 1; addr = BASE + 16; width = 2'd2; wdata = 32'hDEAD_BEEF; drv = 1'b1; wr = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("rst_wait_ok", {31'b0, obs_ok}, 32'd0);
        wr = 1'b0; drv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_ok", {31'b0, obs_ok}, 32'd0);
        end
        rst = 1'b0;
        xfer(1, 0, BASE + 16, 2'd2, 32'h0BAD_F00D, 4, 0);

        // Reset during an ACK cycle drops mem_ok and the bus at once
        @(posedge clk); #1;
        sel = 1; addr = BASE + 16; rd = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_ack", {31'b0, obs_ok}, 32'd1);
        #1 rst = 1'b1;
        #1 check("rst_ack_ok", {31'b0, obs_ok}, 32'd0);
        check("rst_ack_bus", {31'b0, obs_rel}, 32'd1);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Unit 2: READ_WAIT=0, held read across two acks
        xfer(2, 1, BASE + 20, 2'd2, 32'h7777_7777, 1, 0);
        xfer(2, 1, BASE + 24, 2'd2, 32'h6666_6666, 1, 0);
        @(posedge clk); #1;
        sel = 2; addr = BASE + 20; rd = 1'b1;
        sb.push_back('{is_rd: 1'b1, data: 32'h7777_7777, lat: 1});
        @(negedge clk);
        check("b2b_n0", {31'b0, obs_ok}, 32'd0);
        @(negedge clk);
        check("b2b_n1", {31'b0, obs_ok}, 32'd1);
        e = sb.pop_front();
        check("b2b_data1", obs_data, e.data);
        @(posedge clk); #1;
        addr = BASE + 24;
        sb.push_back('{is_rd: 1'b1, data: 32'h6666_6666, lat: 3});
        @(negedge clk);
        check("b2b_n2", {31'b0, obs_ok}, 32'd0);
        @(negedge clk);
        check("b2b_n3", {31'b0, obs_ok}, 32'd1);
        e = sb.pop_front();
        check("b2b_data2", obs_data, e.data);
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        check("b2b_after", {31'b0, obs_ok}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
